// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 datapath blocks: PRGA state encoding,
// S memory geometry and the printable-plaintext bounds.
package rc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] ASCII_LO    = 8'h61;
    localparam logic [BYTE_W-1:0] ASCII_HI    = 8'h7A;
    localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        WT_SI,
        SV_SI,
        RD_SJ,
        WT_SJ,
        SV_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WT_F,
        SV_F,
        WR_DEC,
        NEXT,
        DONE
    } rc4_state_t;

    function automatic logic ascii_ok(input logic [BYTE_W-1:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SPACE);
    endfunction

endpackage

// File: rtl/rc4_wait_counter.sv
// Memory read-latency timer: load arms it with RD_LAT, expire is high during
// the last wait cycle.
module rc4_wait_counter #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= 8'(RD_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = (cnt == 8'd1);

endmodule

// File: rtl/rc4_decrypt_loop.sv
// RC4 PRGA + XOR decryption over the permuted S memory.
// Define RC4_ASCII_CHECK_EN to abort on the first non-printable plaintext byte.
module rc4_decrypt_loop
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_flag,
    output logic       done_flag,
    output logic       invalid_flag,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    input  logic [7:0] s_data_read,
    output logic       s_wren,
    output logic [7:0] enc_address,
    input  logic [7:0] enc_data_read,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren
);

    rc4_state_t        state;
    logic [BYTE_W-1:0] i, j, data_i, data_j, f, enc_byte;
    logic [8:0]        k;
    logic              wait_load, wait_expire;
    logic [BYTE_W-1:0] plain;

    assign wait_load = (state == RD_SI) || (state == RD_SJ) || (state == RD_F);
    assign plain     = s_data_read ^ enc_data_read;
    assign done_flag = (state == DONE);
    assign dec_data  = f ^ enc_byte;

    rc4_wait_counter #(.RD_LAT(RD_LAT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .load   (wait_load),
        .expire (wait_expire)
    );

`ifdef RC4_ASCII_CHECK_EN
    logic invalid_r;
    assign invalid_flag = invalid_r;
`else
    assign invalid_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            data_i      <= '0;
            data_j      <= '0;
            f           <= '0;
            enc_byte    <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            enc_address <= '0;
            dec_address <= '0;
            dec_wren    <= 1'b0;
`ifdef RC4_ASCII_CHECK_EN
            invalid_r   <= 1'b0;
`endif
        end else if (!start_flag) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
`ifdef RC4_ASCII_CHECK_EN
            invalid_r <= 1'b0;
`endif
        end else begin
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
            // Memory-facing outputs are loaded on the edge entering the state that uses them.
            case (state)
                IDLE:  state <= INC_I;
                INC_I: begin
                    i         <= i + 8'd1;
                    s_address <= i + 8'd1;
                    state     <= RD_SI;
                end
                RD_SI: state <= WT_SI;
                WT_SI: if (wait_expire) state <= SV_SI;
                SV_SI: begin
                    data_i    <= s_data_read;
                    j         <= j + s_data_read;
                    s_address <= j + s_data_read;
                    state     <= RD_SJ;
                end
                RD_SJ: state <= WT_SJ;
                WT_SJ: if (wait_expire) state <= SV_SJ;
                SV_SJ: begin
                    data_j    <= s_data_read;
                    s_address <= i;
                    s_data    <= s_data_read;
                    s_wren    <= 1'b1;
                    state     <= WR_SI;
                end
                WR_SI: begin
                    s_address <= j;
                    s_data    <= data_i;
                    s_wren    <= 1'b1;
                    state     <= WR_SJ;
                end
                WR_SJ: begin
                    s_address   <= data_i + data_j;
                    enc_address <= k[7:0];
                    state       <= RD_F;
                end
                RD_F: state <= WT_F;
                WT_F: if (wait_expire) state <= SV_F;
                SV_F: begin
                    f        <= s_data_read;
                    enc_byte <= enc_data_read;
`ifdef RC4_ASCII_CHECK_EN
                    if (!ascii_ok(plain)) begin
                        invalid_r <= 1'b1;
                        state     <= DONE;
                    end else begin
                        dec_address <= k[7:0];
                        dec_wren    <= 1'b1;
                        state       <= WR_DEC;
                    end
`else
                    dec_address <= k[7:0];
                    dec_wren    <= 1'b1;
                    state       <= WR_DEC;
`endif
                end
                WR_DEC: state <= NEXT;
                NEXT: begin
                    k     <= k + 9'd1;
                    state <= (k == 9'(MSG_LEN - 1)) ? DONE : INC_I;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RC4_ASCII_CHECK_EN
    logic unused_plain;
    assign unused_plain = ^plain;
`endif

endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// Self-checking bench for rc4_decrypt_loop against a plain-array RC4 PRGA model.
module tb_rc4_decrypt_loop;
    import rc4_pkg::*;

    localparam int MSG_LEN = 32;
    localparam int RD_LAT  = 2;

    logic       clk = 1'b0;
    logic       reset, start_flag;
    logic       done_flag, invalid_flag;
    logic [7:0] s_address, s_data, s_data_read;
    logic       s_wren;
    logic [7:0] enc_address, enc_data_read;
    logic [7:0] dec_address, dec_data;
    logic       dec_wren;

    rc4_decrypt_loop #(.MSG_LEN(MSG_LEN), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_flag    (start_flag),
        .done_flag     (done_flag),
        .invalid_flag  (invalid_flag),
        .s_address     (s_address),
        .s_data        (s_data),
        .s_data_read   (s_data_read),
        .s_wren        (s_wren),
        .enc_address   (enc_address),
        .enc_data_read (enc_data_read),
        .dec_address   (dec_address),
        .dec_data      (dec_data),
        .dec_wren      (dec_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem   [S_DEPTH];
    logic [7:0] s_init  [S_DEPTH];
    logic [7:0] enc_mem [S_DEPTH];
    logic [7:0] dec_mem [S_DEPTH];
    logic [7:0] zero_mem[S_DEPTH];
    logic       load_s = 1'b0;
    int         s_wr_cnt = 0;
    int         dec_wr_cnt = 0;

    always @(posedge clk) begin
        if (load_s) begin
            s_mem   <= s_init;
            dec_mem <= zero_mem;
        end else begin
            if (s_wren)   s_mem[s_address]     <= s_data;
            if (dec_wren) dec_mem[dec_address] <= dec_data;
        end
        s_data_read   <= s_mem[s_address];
        enc_data_read <= enc_mem[enc_address];
        if (s_wren)   s_wr_cnt   <= s_wr_cnt + 1;
        if (dec_wren) dec_wr_cnt <= dec_wr_cnt + 1;
    end

    // Reference RC4 PRGA on plain arrays
    logic [7:0] m_s  [S_DEPTH];
    logic [7:0] m_dec[S_DEPTH];
    int         m_bytes;
    bit         m_invalid;

    task automatic model_run(input int n);
        int ii, jj;
        logic [7:0] t, p;
        ii = 0; jj = 0; m_bytes = 0; m_invalid = 0;
        for (int kk = 0; kk < n; kk++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(m_s[ii])) % 256;
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            p = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256] ^ enc_mem[kk];
`ifdef RC4_ASCII_CHECK_EN
            if (!((p >= 8'h61 && p <= 8'h7a) || p == 8'h20)) begin
                m_invalid = 1;
                return;
            end
`endif
            m_dec[kk] = p;
            m_bytes++;
        end
    endtask

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {done_flag, invalid_flag, s_address, s_data, s_wren,
                    enc_address, dec_address, dec_data, dec_wren}, 32'h0);
    endtask

    task automatic load_memories;
        for (int x = 0; x < S_DEPTH; x++) m_s[x] = s_init[x];
        load_s = 1'b1;
        @(posedge clk); #1;
        load_s = 1'b0;
    endtask

    task automatic make_perm(input bit pin_ff);
        int p;
        logic [7:0] t;
        for (int x = 0; x < S_DEPTH; x++) s_init[x] = 8'(x);
        for (int x = S_DEPTH - 1; x > 0; x--) begin
            p = int'($urandom_range(x, 0));
            t = s_init[x]; s_init[x] = s_init[p]; s_init[p] = t;
        end
        if (pin_ff) begin
            for (int x = 0; x < S_DEPTH; x++) if (s_init[x] == 8'hFF) p = x;
            t = s_init[1]; s_init[1] = s_init[p]; s_init[p] = t;
            for (int x = 0; x < S_DEPTH; x++) if (s_init[x] == 8'h01) p = x;
            t = s_init[8'hFF]; s_init[8'hFF] = s_init[p]; s_init[p] = t;
        end
    endtask

    // Raises start (away from an edge) and counts edges, inclusive of the first sampling edge.
    task automatic run_and_check(input string tag);
        int edges, s0, d0, mism;
        s0 = s_wr_cnt; d0 = dec_wr_cnt;
        model_run(MSG_LEN);
        start_flag = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done_flag && edges < 17 * MSG_LEN + 50);
        check({tag, "_done"}, 32'(done_flag), 32'h1);
        check({tag, "_latency"}, 32'(edges),
              m_invalid ? 32'(17 * m_bytes + 16) : 32'(17 * MSG_LEN + 1));
        check({tag, "_invalid"}, 32'(invalid_flag), 32'(m_invalid));
        check({tag, "_s_writes"}, 32'(s_wr_cnt - s0),
              32'(m_invalid ? 2 * (m_bytes + 1) : 2 * m_bytes));
        check({tag, "_dec_writes"}, 32'(dec_wr_cnt - d0), 32'(m_bytes));
        for (int x = 0; x < m_bytes; x++)
            check($sformatf("%s_dec%0d", tag, x), 32'(dec_mem[x]), 32'(m_dec[x]));
        mism = 0;
        for (int x = 0; x < S_DEPTH; x++) if (s_mem[x] !== m_s[x]) mism++;
        check({tag, "_s_final_mismatches"}, 32'(mism), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, 32'(done_flag), 32'h1);
        start_flag = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, {30'h0, done_flag, invalid_flag}, 32'h0);
    endtask

    initial begin
        int s0, d0, mism;
        for (int x = 0; x < S_DEPTH; x++) begin
            zero_mem[x] = 8'h00;
            s_mem[x]    = 8'h00;
            enc_mem[x]  = 8'h00;
            dec_mem[x]  = 8'h00;
        end
        reset = 1'b1;
        start_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("idle_outputs");

        // Identity S, zero ciphertext
        for (int x = 0; x < S_DEPTH; x++) s_init[x] = 8'(x);
        load_memories();
        run_and_check("identity");
`ifndef RC4_ASCII_CHECK_EN
        check("identity_dec0_const", 32'(dec_mem[0]), 32'h02);
        check("identity_dec1_const", 32'(dec_mem[1]), 32'h05);
`endif

        // Random permutations; first one pins S[1]=FF, S[FF]=01 to force j wrap
        for (int r = 0; r < 2; r++) begin
            make_perm(r == 0);
            for (int x = 0; x < S_DEPTH; x++) enc_mem[x] = 8'($urandom);
            load_memories();
            run_and_check($sformatf("rand%0d", r));
        end

`ifndef RC4_ASCII_CHECK_EN
        // Drop start during WT_SJ of byte 3 (entered on edge 17*3+6)
        make_perm(1'b0);
        for (int x = 0; x < S_DEPTH; x++) enc_mem[x] = 8'($urandom);
        load_memories();
        model_run(3);
        start_flag = 1'b1;
        repeat (17 * 3 + 7) @(posedge clk);
        #1;
        start_flag = 1'b0;
        @(posedge clk); #1;
        check("abort_wren_low", {30'h0, s_wren, dec_wren}, 32'h0);
        check("abort_done_low", 32'(done_flag), 32'h0);
        s0 = s_wr_cnt; d0 = dec_wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_writes", 32'((s_wr_cnt - s0) + (dec_wr_cnt - d0)), 32'h0);
        mism = 0;
        for (int x = 0; x < S_DEPTH; x++) if (s_mem[x] !== m_s[x]) mism++;
        check("abort_s_mismatches", 32'(mism), 32'h0);
        run_and_check("restart");

        // Async reset while in WR_DEC of byte 0 (entered on edge 15)
        start_flag = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("wrdec_wren", 32'(dec_wren), 32'h1);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset_outputs");
        start_flag = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_outputs_zero("post_reset_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
